adder_tree_49_ctrl: RTL and testbench

ADDER_TREE_49_CTRL -- requirements
Module: adder_tree_49_ctrl

---
 rtl/adder_tree_49_ctrl.sv | 129 ++++++++++++
 tb/tb_adder_tree_49_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_49_ctrl.sv
// rtl/adder_tree_49_ctrl.sv - frame controller for a 49-input pipelined adder tree
//
// Sequences one frame of FRAME_LEN windows through an external TREE_LAT-stage
// adder tree, tracks which pipeline slots hold real windows, and applies
// result back-pressure by freezing the whole tree.
//
// Optional feature macro: ADDER_TREE_CTRL_RELU_EN (clamp negative results to 0).
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, abort         frame start pulse, frame cancel
//   in_valid, in_ready   window-source handshake (window data goes straight to the tree)
//   tree_en              enable for every adder-tree pipeline register
//   tree_sum             signed Q22.16 tree output
//   out_valid, out_ready result handshake
//   out_data             signed Q22.16 result
//   busy                 high whenever not IDLE
//   frame_done           one-cycle pulse at frame completion
module adder_tree_49_ctrl #(
    parameter int FRAME_LEN = 784,
    parameter int CNT_W     = 16,
    parameter int TREE_LAT  = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tree_en,
    input  logic [37:0] tree_sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [37:0] out_data,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    in_cnt, out_cnt;
    logic [TREE_LAT-1:0] vld, vld_nxt;
    logic                accept;
    logic                out_hs;
    logic                active;
    logic                kill;
    logic                clr;

    // A result waiting on out_ready freezes the tree so nothing moves or is lost.
    assign out_valid = vld[TREE_LAT-1];
    assign tree_en   = !(out_valid && !out_ready);
    assign out_hs    = out_valid && out_ready;
    assign active    = (state == RUN) || (state == DRAIN);
    assign kill      = abort && active;
    assign clr       = kill || (state == DONE);
    assign busy      = (state != IDLE);

`ifdef ADDER_TREE_CTRL_RELU_EN
    assign out_data = tree_sum[37] ? '0 : tree_sum;
`else
    assign out_data = tree_sum;
`endif

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                // abort is ignored here, so start wins when both are high
                if (start) state_nxt = RUN;
            end
            RUN: begin
                in_ready = tree_en;
                accept   = in_valid && tree_en;
                if (abort)                           state_nxt = IDLE;
                else if (accept && (in_cnt == LAST)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort)                            state_nxt = IDLE;
                else if (out_hs && (out_cnt == LAST)) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Valid tracker mirrors the tree pipeline: it shifts exactly when the tree does.
    always_comb begin
        vld_nxt = vld;
        if (kill) begin
            vld_nxt = '0;
        end else if (tree_en) begin
            vld_nxt[0] = accept;
            for (int i = 1; i < TREE_LAT; i++) begin
                vld_nxt[i] = vld[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            vld     <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            state <= state_nxt;
            vld   <= vld_nxt;
            if (clr)         in_cnt <= '0;
            else if (accept) in_cnt <= in_cnt + 1'b1;
            if (clr)                   out_cnt <= '0;
            else if (out_hs && active) out_cnt <= out_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_tree_49_ctrl.sv
// tb/tb_adder_tree_49_ctrl.sv - directed self-checking bench for adder_tree_49_ctrl
module tb_adder_tree_49_ctrl;

    localparam int LAT = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: FRAME_LEN = 4
    logic        start_a = 0, abort_a = 0, in_valid_a = 0, out_ready_a = 1;
    logic        in_ready_a, tree_en_a, out_valid_a, busy_a, frame_done_a;
    logic [37:0] in_flat_a = '0, tree_sum_a, out_data_a;
    logic [37:0] tp_a [LAT];

    // DUT B: FRAME_LEN = 1
    logic        start_b = 0, abort_b = 0, in_valid_b = 0, out_ready_b = 1;
    logic        in_ready_b, tree_en_b, out_valid_b, busy_b, frame_done_b;
    logic [37:0] in_flat_b = '0, tree_sum_b, out_data_b;
    logic [37:0] tp_b [LAT];

    adder_tree_49_ctrl #(.FRAME_LEN(4), .CNT_W(16), .TREE_LAT(LAT)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .tree_en(tree_en_a),
        .tree_sum(tree_sum_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(out_data_a), .busy(busy_a), .frame_done(frame_done_a)
    );

    adder_tree_49_ctrl #(.FRAME_LEN(1), .CNT_W(16), .TREE_LAT(LAT)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .tree_en(tree_en_b),
        .tree_sum(tree_sum_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .busy(busy_b), .frame_done(frame_done_b)
    );

    // Stand-in adder trees: the window sum is presented as in_flat and delayed LAT enabled cycles.
    always @(posedge clk) begin
        if (tree_en_a) begin
            tp_a[0] <= in_flat_a;
            for (int i = 1; i < LAT; i++) tp_a[i] <= tp_a[i-1];
        end
        if (tree_en_b) begin
            tp_b[0] <= in_flat_b;
            for (int i = 1; i < LAT; i++) tp_b[i] <= tp_b[i-1];
        end
    end
    assign tree_sum_a = tp_a[LAT-1];
    assign tree_sum_b = tp_b[LAT-1];

    // Output monitors, sampled mid-cycle
    logic [37:0] q_a [$];
    int          fd_a = 0, first_out = -1, first_acc = -1;
    int          out_b = 0, fd_b = 0, fd_run_b = 0, fd_max_b = 0;
    logic [37:0] data_b = '0;

    always @(negedge clk) begin
        if (out_valid_a && out_ready_a) q_a.push_back(out_data_a);
        if (out_valid_a && first_out < 0) first_out = cyc;
        if (frame_done_a) fd_a++;
        if (out_valid_b && out_ready_b) begin
            out_b++;
            data_b = out_data_b;
        end
        if (frame_done_b) begin
            if (fd_run_b == 0) fd_b++;
            fd_run_b++;
            if (fd_run_b > fd_max_b) fd_max_b = fd_run_b;
        end else begin
            fd_run_b = 0;
        end
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_a();
        q_a.delete();
        fd_a      = 0;
        first_out = -1;
        first_acc = -1;
    endtask

    task automatic pulse_start_a();
        @(posedge clk); #1 start_a = 1;
        @(posedge clk); #1 start_a = 0;
    endtask

    task automatic send_a(input logic [37:0] v);
        int n;
        n = 0;
        in_valid_a = 1;
        in_flat_a  = v;
        @(negedge clk);
        while (!in_ready_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", in_ready_a, 1);
        @(posedge clk); #1;
        if (first_acc < 0) first_acc = cyc;
        in_valid_a = 0;
    endtask

    task automatic wait_fd_a(input int target);
        int n;
        n = 0;
        while (fd_a < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_wait", fd_a, target);
    endtask

    logic [37:0] exp_neg;
    logic [37:0] stall_vals [4];

    initial begin
`ifdef ADDER_TREE_CTRL_RELU_EN
        exp_neg = 38'h0;
`else
        exp_neg = 38'h3FFFFE0000;
`endif
        // Reset values
        #3;
        chk("rst_in_ready",   in_ready_a,   0);
        chk("rst_out_valid",  out_valid_a,  0);
        chk("rst_busy",       busy_a,       0);
        chk("rst_frame_done", frame_done_a, 0);
        chk("rst_tree_en",    tree_en_a,    1);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Four back-to-back windows of 1.0
        clear_a();
        out_ready_a = 1;
        pulse_start_a();
        chk("run_busy",     busy_a,     1);
        chk("run_in_ready", in_ready_a, 1);
        repeat (4) send_a(38'h10000);
        wait_fd_a(1);
        chk("f1_count", q_a.size(), 4);
        for (int i = 0; i < 4; i++) chk("f1_data", (q_a.size() > i) ? q_a[i] : 38'h0, 38'h10000);
        chk("f1_latency", first_out - first_acc, LAT - 1);
        @(negedge clk);
        chk("f1_fd_once", fd_a, 1);
        chk("f1_idle",    busy_a, 0);

        // Stall for three cycles while a result is presented; includes a -2.0 window
        clear_a();
        stall_vals[0] = 38'h10000;
        stall_vals[1] = 38'h3FFFFE0000;
        stall_vals[2] = 38'h30000;
        stall_vals[3] = 38'h40000;
        out_ready_a = 0;
        pulse_start_a();
        for (int i = 0; i < 4; i++) send_a(stall_vals[i]);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid_a && n < 50);
        end
        for (int k = 0; k < 3; k++) begin
            chk("stall_tree_en",  tree_en_a,  0);
            chk("stall_in_ready", in_ready_a, 0);
            chk("stall_data",     out_data_a, 38'h10000);
            if (k < 2) @(negedge clk);
        end
        @(posedge clk); #1 out_ready_a = 1;
        wait_fd_a(1);
        chk("f2_count", q_a.size(), 4);
        chk("f2_d0", (q_a.size() > 0) ? q_a[0] : 38'h0, 38'h10000);
        chk("f2_neg", (q_a.size() > 1) ? q_a[1] : 38'h1, exp_neg);
        chk("f2_d2", (q_a.size() > 2) ? q_a[2] : 38'h0, 38'h30000);
        chk("f2_d3", (q_a.size() > 3) ? q_a[3] : 38'h0, 38'h40000);

        // Abort after two accepts, then a full frame
        clear_a();
        pulse_start_a();
        send_a(38'h10000);
        send_a(38'h10000);
        abort_a = 1;
        @(posedge clk); #1 abort_a = 0;
        chk("abort_idle", busy_a, 0);
        @(negedge clk);
        chk("abort_out_valid", out_valid_a, 0);
        repeat (10) @(negedge clk);
        chk("abort_no_out", q_a.size(), 0);
        chk("abort_no_fd",  fd_a, 0);
        clear_a();
        pulse_start_a();
        repeat (4) send_a(38'h50000);
        wait_fd_a(1);
        chk("f3_count", q_a.size(), 4);
        for (int i = 0; i < 4; i++) chk("f3_data", (q_a.size() > i) ? q_a[i] : 38'h0, 38'h50000);

        // Reset mid-DRAIN with three results in flight
        clear_a();
        pulse_start_a();
        repeat (4) send_a(38'h10000);
        repeat (3) begin @(posedge clk); #1; end
        chk("drain_one_out", q_a.size(), 1);
        rst = 1;
        #1;
        chk("mid_rst_out_valid",  out_valid_a,  0);
        chk("mid_rst_in_ready",   in_ready_a,   0);
        chk("mid_rst_busy",       busy_a,       0);
        chk("mid_rst_tree_en",    tree_en_a,    1);
        chk("mid_rst_frame_done", frame_done_a, 0);
        @(posedge clk); #1 rst = 0;
        clear_a();
        repeat (12) @(negedge clk);
        chk("post_rst_no_stale", q_a.size(), 0);
        chk("post_rst_no_fd",    fd_a, 0);
        pulse_start_a();
        repeat (4) send_a(38'h10000);
        wait_fd_a(1);
        chk("f4_count", q_a.size(), 4);

        // FRAME_LEN = 1 with gapped input
        @(posedge clk); #1 start_b = 1;
        @(posedge clk); #1 start_b = 0;
        in_flat_b = 38'h20000;
        for (int r = 0; r < 3; r++) begin
            in_valid_b = 1;
            @(posedge clk); #1 in_valid_b = 0;
            repeat (2) begin @(posedge clk); #1; end
        end
        begin
            int n;
            n = 0;
            while (fd_b < 1 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (8) @(negedge clk);
        chk("b_outputs",  out_b,    1);
        chk("b_data",     data_b,   38'h20000);
        chk("b_fd_count", fd_b,     1);
        chk("b_fd_width", fd_max_b, 1);
        chk("b_idle",     busy_b,   0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
